pipeline_hazard_ctrl: RTL

Central stall/flush scheduler for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). Consumes the decoded control flags already carried in the ID/EX and EX/MEM pipeline registers, plus the data-memory ready handshake. Produces every pipeline-register enable/flush, the PC source select, and saturating stall/flush performance counters. Holds a small wait FSM that freezes the whole pipeline while a data-memory access is outstanding, with a timeout guard.

---
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: data-memory wait FSM with
// timeout guard, load-use and control-hazard resolution, and saturating
// stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_wait,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC-1:0] TIMEOUT_V = WC'(MEM_TIMEOUT);

    typedef enum logic {RUN, WAIT} state_t;

    state_t          state, state_next;
    logic [WC-1:0]   wait_cnt, wait_cnt_next;
    logic            mem_err_next;
    logic            freeze;
    logic            load_use;
    logic            stall_inc;
    logic            flush_inc;

    assign freeze = ((state == RUN) && mem_req && !dmem_ready) ||
                    ((state == WAIT) && !dmem_ready && (wait_cnt != TIMEOUT_V));

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((id_rs_used && (id_rs == ex_rt)) || (id_rt_used && (id_rt == ex_rt)));

    assign stall_inc = freeze || (load_use && !ex_branch_taken);
    assign flush_inc = !freeze && (ex_branch_taken || (!load_use && id_jump));

    // Wait-FSM state register, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            mem_err  <= mem_err_next;
        end
    end

    // Wait-FSM next state: enter on a missed access, leave on ready or timeout
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        mem_err_next  = mem_err;
        case (state)
            RUN: begin
                if (mem_req && !dmem_ready) begin
                    state_next    = WAIT;
                    wait_cnt_next = WC'(1);
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == TIMEOUT_V) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                    mem_err_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + WC'(1);
                end
            end
        endcase
    end

    // Pipeline controls by strict priority: reset, freeze, branch, load-use, jump
    always_comb begin
        pc_en        = 1'b1;
        pc_src       = 2'b00;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        mem_wait     = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            mem_wait     = 1'b1;
        end else if (ex_branch_taken) begin
            pc_src      = 2'b01;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (id_jump) begin
            pc_src      = 2'b10;
            if_id_flush = 1'b1;
        end
    end

    // Saturating performance counters; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
